// File: rtl/segm7_pkg.sv
// segm7_pkg: register offsets, scan FSM states and hex-to-segment table shared by the segm7 scan driver
package segm7_pkg;
    localparam logic [15:0] ADDR_DATA = 16'h0000;
    localparam logic [15:0] ADDR_MASK = 16'h0004;
    localparam logic [15:0] ADDR_CTRL = 16'h0008;
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT_HI, SHIFT_LO, LATCH, DWELL} scan_state_t;
    localparam logic [111:0] SEG_LUT = {7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
                                        7'h72, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E};
    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        return SEG_LUT[int'(h) * 7 +: 7];
    endfunction
endpackage

// File: rtl/segm7_shift595.sv
// segm7_shift595: LSB-first 8-bit shifter for one 74HC595 chain; ports: clk/reset, load/shift_hi/shift_lo strobes, din byte, ser/srclk pins
module segm7_shift595 (
    input  logic       S_AXI_ACLK,
    input  logic       S_AXI_ARSTN,
    input  logic       load,
    input  logic       shift_hi,
    input  logic       shift_lo,
    input  logic [7:0] din,
    output logic       ser,
    output logic       srclk
);
    logic [7:0] sr;
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARSTN) begin
        if (!S_AXI_ARSTN) begin
            sr    <= '0;
            ser   <= 1'b0;
            srclk <= 1'b0;
        end else if (load) begin
            sr    <= din;
            ser   <= din[0];
            srclk <= 1'b0;
        end else if (shift_hi) begin
            srclk <= 1'b1;
        end else if (shift_lo) begin
            sr    <= {1'b0, sr[7:1]};
            ser   <= sr[1];
            srclk <= 1'b0;
        end
    end
endmodule

// File: rtl/segm7_scan_driver.sv
// segm7_scan_driver: AXI-lite-style DATA/MASK/CTRL registers driving a multiplexed 7-seg display through COM and SEG 74HC595 chains; ports: S_AXI_* bus, reg_data_out, COM_*/SEG_* SER/SRCLK/RCLK
module segm7_scan_driver
    import segm7_pkg::*;
#(
    parameter int NUM_DIGITS         = 8,
    parameter int CLK_DIV            = 4,
    parameter int DWELL_TICKS        = 1024,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 16
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARSTN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic                          S_AXI_WVALID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg_data_out,
    output logic                          COM_SER,
    output logic                          COM_SRCLK,
    output logic                          COM_RCLK,
    output logic                          SEG_SER,
    output logic                          SEG_SRCLK,
    output logic                          SEG_RCLK
);
    localparam logic [2:0]  LAST_DIGIT = 3'(NUM_DIGITS - 1);
    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [20:0] DWELL_LAST = 21'(DWELL_TICKS - 1);
    logic [31:0] data_reg, data_snap, src_data;
    logic [15:0] mask_reg, mask_snap, src_mask;
    logic        ctrl_en, tick, blank, blank_n, ld, sh_hi, sh_lo, rclk;
    logic [15:0] div_cnt;
    logic [2:0]  digit, digit_n, bit_cnt, bit_n;
    logic [20:0] dwell_cnt, dwell_n;
    logic [3:0]  nib;
    logic [7:0]  com_byte, seg_byte;
    scan_state_t state, state_n;
    assign tick = div_cnt == DIV_LAST;
    assign reg_data_out = S_AXI_ARADDR == C_S_AXI_ADDR_WIDTH'(ADDR_DATA) ? C_S_AXI_DATA_WIDTH'(data_reg) :
                          S_AXI_ARADDR == C_S_AXI_ADDR_WIDTH'(ADDR_MASK) ? C_S_AXI_DATA_WIDTH'(mask_reg) :
                          S_AXI_ARADDR == C_S_AXI_ADDR_WIDTH'(ADDR_CTRL) ? C_S_AXI_DATA_WIDTH'(ctrl_en) : '0;
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARSTN) begin
        if (!S_AXI_ARSTN) begin
            data_reg <= '0;
            mask_reg <= '0;
            ctrl_en  <= 1'b0;
        end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
            if (S_AXI_AWADDR == C_S_AXI_ADDR_WIDTH'(ADDR_DATA)) data_reg <= S_AXI_WDATA[31:0];
            if (S_AXI_AWADDR == C_S_AXI_ADDR_WIDTH'(ADDR_MASK)) mask_reg <= S_AXI_WDATA[15:0];
            if (S_AXI_AWADDR == C_S_AXI_ADDR_WIDTH'(ADDR_CTRL)) ctrl_en  <= S_AXI_WDATA[0];
        end
    end
    always_comb begin
        state_n = state;
        digit_n = digit;
        blank_n = blank;
        bit_n   = bit_cnt;
        dwell_n = dwell_cnt;
        case (state)
            IDLE:     state_n = ctrl_en ? LOAD : IDLE;
            LOAD:     state_n = SHIFT_HI;
            SHIFT_HI: state_n = SHIFT_LO;
            SHIFT_LO: begin
                bit_n   = bit_cnt + 3'd1;
                state_n = bit_cnt == 3'd7 ? LATCH : SHIFT_HI;
            end
            LATCH: begin
                state_n = blank ? IDLE : DWELL;
                digit_n = blank ? 3'd0 : digit;
                blank_n = 1'b0;
            end
            DWELL: begin
                dwell_n = dwell_cnt == DWELL_LAST ? 21'd0 : dwell_cnt + 21'd1;
                if (dwell_cnt == DWELL_LAST) begin
                    state_n = LOAD;
                    blank_n = !ctrl_en;
                    digit_n = !ctrl_en ? digit : digit == LAST_DIGIT ? 3'd0 : digit + 3'd1;
                end
            end
            default:  state_n = IDLE;
        endcase
    end
    // Bytes are built for the digit being entered; digit 0 reads the live registers, which are snapshotted at the same time
    always_comb begin
        src_data = digit_n == 3'd0 ? data_reg : data_snap;
        src_mask = digit_n == 3'd0 ? mask_reg : mask_snap;
        nib      = src_data[{digit_n, 2'b00} +: 4];
        com_byte = blank_n ? 8'hFF : ~(8'h01 << digit_n);
        seg_byte = (blank_n || src_mask[{2'b01, digit_n}]) ? 8'h00 : {src_mask[{2'b00, digit_n}], hex2seg(nib)};
    end
    assign ld    = tick && state_n == LOAD;
    assign sh_hi = tick && state_n == SHIFT_HI;
    assign sh_lo = tick && state_n == SHIFT_LO;
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARSTN) begin
        if (!S_AXI_ARSTN) begin
            div_cnt   <= '0;
            state     <= IDLE;
            digit     <= '0;
            bit_cnt   <= '0;
            dwell_cnt <= '0;
            blank     <= 1'b0;
            rclk      <= 1'b0;
            data_snap <= '0;
            mask_snap <= '0;
        end else begin
            div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
            if (tick) begin
                state     <= state_n;
                digit     <= digit_n;
                bit_cnt   <= bit_n;
                dwell_cnt <= dwell_n;
                blank     <= blank_n;
                rclk      <= state_n == LATCH;
            end
            if (ld && digit_n == 3'd0) begin
                data_snap <= data_reg;
                mask_snap <= mask_reg;
            end
        end
    end
    assign COM_RCLK = rclk;
    assign SEG_RCLK = rclk;
    segm7_shift595 u_com (
        .S_AXI_ACLK (S_AXI_ACLK),
        .S_AXI_ARSTN(S_AXI_ARSTN),
        .load       (ld),
        .shift_hi   (sh_hi),
        .shift_lo   (sh_lo),
        .din        (com_byte),
        .ser        (COM_SER),
        .srclk      (COM_SRCLK)
    );
    segm7_shift595 u_seg (
        .S_AXI_ACLK (S_AXI_ACLK),
        .S_AXI_ARSTN(S_AXI_ARSTN),
        .load       (ld),
        .shift_hi   (sh_hi),
        .shift_lo   (sh_lo),
        .din        (seg_byte),
        .ser        (SEG_SER),
        .srclk      (SEG_SRCLK)
    );
endmodule

// File: tb/tb_segm7_scan_driver.sv
// tb_segm7_scan_driver: table-driven bench decoding both 595 chains into latched COM/SEG bytes
module tb_segm7_scan_driver;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [15:0] awaddr = '0, araddr = '0;
    logic [31:0] wdata = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0;
    logic [31:0] rdo, rdo3;
    logic        com_ser, com_srclk, com_rclk, seg_ser, seg_srclk, seg_rclk;
    logic        c3_ser, c3_srclk, c3_rclk, s3_ser, s3_srclk, s3_rclk;
    int          errors = 0, checks = 0, cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    segm7_scan_driver #(.NUM_DIGITS(8), .CLK_DIV(4), .DWELL_TICKS(4)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARSTN(rst_n), .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid),
        .S_AXI_WDATA(wdata), .S_AXI_WVALID(wvalid), .S_AXI_ARADDR(araddr), .reg_data_out(rdo),
        .COM_SER(com_ser), .COM_SRCLK(com_srclk), .COM_RCLK(com_rclk),
        .SEG_SER(seg_ser), .SEG_SRCLK(seg_srclk), .SEG_RCLK(seg_rclk));
    segm7_scan_driver #(.NUM_DIGITS(3), .CLK_DIV(4), .DWELL_TICKS(4)) dut3 (
        .S_AXI_ACLK(clk), .S_AXI_ARSTN(rst_n), .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid),
        .S_AXI_WDATA(wdata), .S_AXI_WVALID(wvalid), .S_AXI_ARADDR(araddr), .reg_data_out(rdo3),
        .COM_SER(c3_ser), .COM_SRCLK(c3_srclk), .COM_RCLK(c3_rclk),
        .SEG_SER(s3_ser), .SEG_SRCLK(s3_srclk), .SEG_RCLK(s3_rclk));
    typedef struct {
        logic [7:0] com;
        logic [7:0] seg;
        int         t;
    } latch_t;
    typedef struct {
        logic [31:0] data;
        logic [15:0] mask;
        logic [63:0] seg;
    } vec_t;
    latch_t     lq[$];
    logic [7:0] q3[$];
    logic [7:0] csh = '0, ssh = '0, c3sh = '0;
    logic       p_cs = 0, p_ss = 0, p_cr = 0, p_sr = 0, p3_s = 0, p3_r = 0;
    int         ccnt = 0, scnt = 0, edges = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!rst_n) begin
            ccnt = 0; scnt = 0; edges = 0;
            p_cs = 0; p_ss = 0; p_cr = 0; p_sr = 0; p3_s = 0; p3_r = 0;
        end else begin
            if (com_srclk && !p_cs) begin csh = {com_ser, csh[7:1]}; ccnt++; edges++; end
            if (seg_srclk && !p_ss) begin ssh = {seg_ser, ssh[7:1]}; scnt++; edges++; end
            if ((com_rclk && !p_cr) || (seg_rclk && !p_sr)) begin
                chk("rclk_together", {30'd0, com_rclk, seg_rclk}, 32'd3);
                chk("com_shifts", ccnt, 8);
                chk("seg_shifts", scnt, 8);
                lq.push_back('{csh, ssh, cyc});
                ccnt = 0; scnt = 0;
            end
            if (c3_srclk && !p3_s) c3sh = {c3_ser, c3sh[7:1]};
            if (c3_rclk && !p3_r) q3.push_back(c3sh);
            p_cs = com_srclk; p_ss = seg_srclk; p_cr = com_rclk; p_sr = seg_rclk;
            p3_s = c3_srclk; p3_r = c3_rclk;
        end
    end
    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
    endtask
    task automatic rd(input logic [15:0] a, input logic [31:0] exp, input string name);
        araddr = a;
        #1;
        chk(name, rdo, exp);
    endtask
    task automatic get_latch(output latch_t l);
        int n = 0;
        while (lq.size() == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (lq.size() == 0) begin
            checks++; errors++;
            $display("FAIL latch_timeout: got no RCLK pulse expected one within 2000 cycles");
            l = '{8'h00, 8'h00, 0};
        end else l = lq.pop_front();
    endtask
    initial begin
        vec_t       vt[5];
        latch_t     l;
        logic [7:0] ec, es;
        int         tprev, e0, n;
        vt[0] = '{32'h76543210, 16'h0000, 64'h725F5B33796D307E};
        vt[1] = '{32'hFEDCBA98, 16'h0000, 64'h474F3D4E1F777B7F};
        vt[2] = '{32'h76543210, 16'h0201, 64'h725F5B33796D00FE};
        vt[3] = '{32'h00000000, 16'hFF00, 64'h0000000000000000};
        vt[4] = '{32'h89ABCDEF, 16'h00AA, 64'hFF7BF71FCE3DCF47};
        tprev = 0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {26'd0, com_ser, com_srclk, com_rclk, seg_ser, seg_srclk, seg_rclk}, 0);
        rst_n = 1'b1;
        rd(16'h0000, 0, "rst_data");
        rd(16'h0004, 0, "rst_mask");
        rd(16'h0008, 0, "rst_ctrl");
        wr(16'h0000, 32'h12345678); rd(16'h0000, 32'h12345678, "rd_data");
        wr(16'h0004, 32'hABCD0201); rd(16'h0004, 32'h00000201, "rd_mask");
        wr(16'h0008, 32'hFFFFFFFE); rd(16'h0008, 32'h0, "rd_ctrl_bit0");
        wr(16'h000C, 32'hDEADBEEF); rd(16'h000C, 32'h0, "rd_unmapped");
        rd(16'h0000, 32'h12345678, "unmapped_no_write");
        for (int k = 0; k < 5; k++) begin
            wr(16'h0000, vt[k].data);
            wr(16'h0004, {16'h0, vt[k].mask});
            if (k == 0) wr(16'h0008, 32'h1);
            for (int i = 0; i < 8; i++) begin
                get_latch(l);
                ec = ~(8'h01 << i);
                es = vt[k].seg[8*i +: 8];
                chk($sformatf("v%0d_com%0d", k, i), l.com, ec);
                chk($sformatf("v%0d_seg%0d", k, i), l.seg, es);
                if (k == 0 && i > 0) chk($sformatf("rclk_period%0d", i), l.t - tprev, 88);
                tprev = l.t;
            end
        end
        for (int i = 0; i < 6; i++) begin
            ec = ~(8'h01 << (i % 3));
            if (q3.size() == 0) begin
                checks++; errors++;
                $display("FAIL nd3_com%0d: got nothing expected %h", i, ec);
            end else chk($sformatf("nd3_com%0d", i), q3.pop_front(), ec);
        end
        for (int i = 0; i < 4; i++) get_latch(l);
        chk("mid_sync_com3", l.com, 8'hF7);
        wr(16'h0000, 32'h76543210);
        for (int i = 4; i < 8; i++) begin
            get_latch(l);
            es = vt[4].seg[8*i +: 8];
            chk($sformatf("mid_old_seg%0d", i), l.seg, es);
        end
        get_latch(l); chk("mid_new_seg0", l.seg, 8'h7E);
        get_latch(l); chk("mid_new_seg1", l.seg, 8'hB0);
        repeat (30) @(negedge clk);
        wr(16'h0008, 32'h0);
        get_latch(l); chk("dis_com2", l.com, 8'hFB); chk("dis_seg2", l.seg, 8'h6D);
        get_latch(l); chk("blank_com", l.com, 8'hFF); chk("blank_seg", l.seg, 8'h00);
        e0 = edges;
        repeat (400) @(negedge clk);
        chk("idle_no_srclk", edges, e0);
        chk("idle_no_latch", lq.size(), 0);
        wr(16'h0008, 32'h1);
        n = 0;
        while (!com_srclk && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!com_srclk) begin
            checks++; errors++;
            $display("FAIL wait_shift_hi: got srclk 0 expected 1 within 200 cycles");
        end
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {26'd0, com_ser, com_srclk, com_rclk, seg_ser, seg_srclk, seg_rclk}, 0);
        rd(16'h0008, 0, "rst_mid_ctrl");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("post_rst_no_srclk", edges, 0);
        chk("post_rst_no_latch", lq.size(), 0);
        wr(16'h0008, 32'h1);
        get_latch(l); chk("restart_com", l.com, 8'hFE); chk("restart_seg", l.seg, 8'h7E);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
